// File: rtl/spi_result_tx.sv
// SPI mode-0 slave transmitter: a single-word holding register feeds a shift register
// that the external master clocks out MSB first; sclk/cs_n are synchronized into clk.
module spi_result_tx #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr,
    input  logic                  oe,
    input  logic                  sclk,
    input  logic                  cs_n,
    output logic                  miso,
    output logic                  full,
    output logic                  busy,
    output logic                  overflow,
    output logic                  underrun
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
    logic                    sclk_prev_q, sclk_prev_d;
    logic                    cs_prev_q, cs_prev_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    full_q, full_d;
    logic                    from_hold_q, from_hold_d;
    logic                    overflow_q, overflow_d;
    logic                    underrun_q, underrun_d;
    logic                    miso_q, miso_d;

    logic                    sclk_s, cs_s;
    logic                    sclk_rise, sclk_fall, cs_fall;
    logic [CW-1:0]           cnt_inc;
    logic                    frame_end;
    logic                    slot_free;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cnt_inc   = cnt_q + CW'(1);
    assign frame_end = sclk_rise && (cnt_inc == CW'(DATA_WIDTH));
    // The held word is released only when the frame that just finished actually sent it.
    assign slot_free = (state_q == DONE) && from_hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (cs_fall) state_d = LOAD;
            LOAD:  state_d = SHIFT;
            SHIFT: begin
                if (frame_end) begin
                    state_d = DONE;
                end else if (cs_s) begin
                    state_d = IDLE;
                end
            end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        miso_d = 1'b0;
        if (oe && !cs_s) begin
            if (state_q == LOAD) begin
                miso_d = full_q ? hold_q[DATA_WIDTH-1] : 1'b0;
            end else if (state_q != IDLE) begin
                miso_d = shift_q[DATA_WIDTH-1];
            end
        end
    end

    assign busy     = (state_q == SHIFT);
    assign miso     = miso_q;
    assign full     = full_q;
    assign overflow = overflow_q;
    assign underrun = underrun_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        hold_d      = hold_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        full_d      = full_q;
        from_hold_d = from_hold_q;
        overflow_d  = overflow_q;
        underrun_d  = underrun_q;

        case (state_q)
            LOAD: begin
                shift_d     = full_q ? hold_q : '0;
                from_hold_d = full_q;
                cnt_d       = '0;
                if (!full_q) underrun_d = 1'b1;
            end
            SHIFT: begin
                if (sclk_fall) shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                if (sclk_rise) cnt_d = cnt_inc;
            end
            default: ;
        endcase

        if (wr) begin
            if (!full_q || slot_free) begin
                hold_d = data_in;
                full_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (slot_free) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            hold_q      <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            from_hold_q <= 1'b0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            from_hold_q <= from_hold_d;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
            miso_q      <= miso_d;
        end
    end

endmodule

// File: tb/tb_spi_result_tx.sv
// Bench for spi_result_tx: a mode-0 SPI master task receives frames, a word-level model
// predicts each frame's content and the status flags, a monitor pops and compares.
module tb_spi_result_tx;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         wr = 1'b0;
    logic         oe = 1'b1;
    logic         sclk = 1'b0;
    logic         cs_n = 1'b1;
    logic         miso, full, busy, overflow, underrun;

    spi_result_tx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr(wr), .oe(oe),
        .sclk(sclk), .cs_n(cs_n), .miso(miso), .full(full), .busy(busy),
        .overflow(overflow), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] rx_q[$];
    int           rx_n_q[$];

    // Word-level model of the transmitter
    bit           m_full = 0;
    logic [W-1:0] m_hold = '0;
    bit           m_over = 0;
    bit           m_under = 0;

    function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_status(string tag);
        check({tag, "_full"}, W'(full), W'(m_full));
        check({tag, "_overflow"}, W'(overflow), W'(m_over));
        check({tag, "_underrun"}, W'(underrun), W'(m_under));
    endfunction

    initial begin : monitor
        logic [W-1:0] r, e;
        int n;
        forever begin
            @(posedge clk);
            if (rx_q.size() > 0) begin
                r = rx_q.pop_front();
                n = rx_n_q.pop_front();
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", r, '0);
                    miscompares += (r === '0) ? 1 : 0;
                end else begin
                    e = exp_q.pop_front() >> (W - n);
                    check("frame_data", r, e);
                end
            end
        end
    end

    task automatic do_wr(input logic [W-1:0] d);
        @(negedge clk);
        data_in = d;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        if (m_full) m_over = 1;
        else begin
            m_hold = d;
            m_full = 1;
        end
        check_status("wr");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_outputs", W'({miso, full, busy, overflow, underrun}), '0);
        @(negedge clk);
        rst_n = 1'b1;
        m_full = 0; m_over = 0; m_under = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frame(input int nbits, input int rst_bit, input bit done_wr,
                         input logic [W-1:0] dd);
        logic [W-1:0] rx;
        bit from_hold, did_rst;
        from_hold = m_full;
        did_rst = 0;
        if (rst_bit < 0) exp_q.push_back(oe ? (m_full ? m_hold : '0) : '0);
        if (!m_full) m_under = 1;
        rx = '0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = {rx[W-2:0], miso};
            sclk = 1'b1;
            if (i == 0) check("busy_in_frame", W'(busy), W'(1));
            if (i == rst_bit) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_midframe", W'({miso, full, busy, overflow, underrun}), '0);
                m_full = 0; m_over = 0; m_under = 0;
                did_rst = 1;
                sclk = 1'b0;
                break;
            end
            if (done_wr && i == nbits - 1) begin
                repeat (3) @(negedge clk);
                data_in = dd;
                wr = 1'b1;
                @(negedge clk);
                wr = 1'b0;
                @(negedge clk);
            end else begin
                repeat (5) @(negedge clk);
            end
            sclk = 1'b0;
            repeat (5) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        if (did_rst) begin
            rst_n = 1'b1;
            repeat (5) @(negedge clk);
        end else begin
            rx_q.push_back(rx);
            rx_n_q.push_back(nbits);
            if (nbits == W) begin
                if (from_hold) m_full = 0;
                if (done_wr) begin
                    if (m_full) m_over = 1;
                    else begin
                        m_hold = dd;
                        m_full = 1;
                    end
                end
            end
        end
        check("busy_after", W'(busy), '0);
        check("miso_idle", W'(miso), '0);
        check_status("frame");
    endtask

    initial begin : stim
        int op;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", W'({miso, full, busy, overflow, underrun}), '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        do_wr(32'h0000000F);
        frame(W, -1, 0, '0);

        do_wr(32'h0000000F);
        do_wr(32'h0000001E);
        frame(W, -1, 0, '0);

        frame(W, -1, 0, '0);

        do_wr(32'hA5A5A5A5);
        frame(12, -1, 0, '0);
        frame(W, -1, 0, '0);

        do_reset();
        do_wr($urandom);
        frame(W, -1, 1, 32'h0000002D);
        frame(W, -1, 0, '0);

        do_wr($urandom);
        oe = 1'b0;
        frame(W, -1, 0, '0);
        oe = 1'b1;

        do_wr($urandom);
        do_wr($urandom);
        frame(W, 16, 0, '0);
        frame(W, -1, 0, '0);

        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 3);
            case (op)
                0, 1: do_wr($urandom);
                2:    frame(W, -1, $urandom_range(0, 1), $urandom);
                default: frame($urandom_range(1, W - 1), -1, 0, '0);
            endcase
        end

        repeat (20) @(negedge clk);
        check("pending_expected", W'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
